image_ram_writer: RTL and testbench
===================================

Name: image_ram_writer

Overview:
- Write-side counterpart of the image ROM: fills a 640x480 byte-addressed image memory from bursts of up to 10 16-bit words.
- Burst width matches the 10-word read port; byte order matches the read side, so readback at the same address returns identical words.
- Accepts bursts over a valid/ready handshake and serializes them into one byte write per clock on a synchronous RAM write port.
- Tracks the frame fill address and reports frame completion.

Parameters:
DEPTH, 307200, image memory size in bytes (640x480)
ADDR_W, 19, memory address width
WORDS, 10, maximum 16-bit words per burst

Ports:
clk  in  1  system clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
start  in  1  pulse: begin new frame at address 0 (honoured only in IDLE or DONE)
in_valid  in  1  burst present on in_data/in_count
in_ready  out  1  writer can accept a burst
in_data  in  16*WORDS  word k on bits [16k+15:16k], k=0..9
in_count  in  4  number of valid words in burst, legal 1..10
mem_we  out  1  byte write strobe
mem_addr  out  ADDR_W  byte write address
mem_wdata  out  8  byte write data
busy  out  1  high in ACCEPT or WRITE
frame_done  out  1  high while in DONE
err  out  1  sticky error, cleared by start or reset

Behaviour:
- Reset (rst_n=0, async): state=IDLE. in_ready, mem_we, busy, frame_done, err = 0. mem_addr=0, mem_wdata=0. Internal address=0, byte counter=0.
- All outputs are registered.
- States: IDLE, ACCEPT, WRITE, DONE.
- IDLE:
  - in_ready=0.
  - start -> ACCEPT, with addr=0 and err=0.
- ACCEPT:
  - in_ready=1.
  - Handshake occurs when in_valid && in_ready at a rising edge. At that edge: capture in_data and in_count, and drop in_ready.
  - in_count=0 or >10: set err, discard burst, stay in ACCEPT.
  - Otherwise -> WRITE with nbytes=2*in_count.
  - If addr+nbytes > DEPTH: set err and truncate nbytes to DEPTH-addr.
- WRITE:
  - One byte per cycle with mem_we=1.
  - Byte j (j=0..nbytes-1): mem_addr = addr+j.
  - Word k occupies bytes 2k and 2k+1: byte 2k = word k [15:8], byte 2k+1 = word k [7:0] (high byte at lower address).
  - First mem_we appears in the cycle after the handshake edge.
  - in_ready=0 throughout WRITE.
  - After the last byte, addr += nbytes and mem_we returns to 0. Then:
    - addr==DEPTH -> DONE
    - otherwise -> ACCEPT
- Burst cost: 1 handshake cycle + 2*in_count write cycles. No back-to-back overlap.
- DONE:
  - frame_done=1, in_ready=0, mem_we=0.
  - start -> ACCEPT with addr=0, err=0, frame_done=0.
- start while in ACCEPT or WRITE is ignored; no restart mid-frame.
- in_data and in_count are don't-care when in_valid=0. in_valid while in_ready=0 is not consumed; the source must hold the burst.
- Reset asserted mid-WRITE: mem_we drops immediately (async) and all state returns to the reset values. Partially written bytes stay in memory.
- Address arithmetic uses ADDR_W+1 bits to detect the DEPTH boundary. mem_addr never exceeds DEPTH-1.

Test Plan:
1. Reset then start; burst in_count=2, words 0xA1B2 and 0xC3D4 -> 4 writes on consecutive cycles: addr0=A1, addr1=B2, addr2=C3, addr3=D4. in_ready returns to 1 one cycle after the last write; err=0.
2. 15360 full bursts (in_count=10, 20 bytes each) -> last write at addr 307199, DONE entered, frame_done=1, in_ready=0. A following start clears frame_done and the next write is at addr 0.
3. Reach addr 307196, then burst in_count=3 -> only 4 writes (307196..307199), err=1, frame_done=1.
4. Burst with in_count=0, then in_count=11 -> no mem_we, err=1, state stays ACCEPT. A following in_count=1 burst, word 0x5566, writes 0x55 and 0x66 at the current addr.
5. Deassert rst_n during byte 5 of a 20-byte burst -> mem_we=0 the same cycle, all outputs at reset values. start then writes the next burst from addr 0.
6. Pulse start during WRITE, and hold in_valid during WRITE -> start ignored, addr continues; the held burst is accepted only at the first ACCEPT cycle after the writes finish.

Source files
------------

// File: rtl/image_ram_writer.sv
// Burst-to-byte image memory writer: accepts up to WORDS 16-bit words per handshake
// and emits one byte write per clock, high byte first, filling a DEPTH-byte frame.
module image_ram_writer #(
    parameter int DEPTH  = 307200,
    parameter int ADDR_W = 19,
    parameter int WORDS  = 10
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [16*WORDS-1:0]   in_data,
    input  logic [3:0]            in_count,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [7:0]            mem_wdata,
    output logic                  busy,
    output logic                  frame_done,
    output logic                  err
);

    localparam int BW = $clog2(2*WORDS+1);
    localparam int IW = $clog2(16*WORDS);
    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);
    localparam logic [3:0]      MAXC    = 4'(WORDS);

    typedef enum logic [1:0] {IDLE, ACCEPT, WRITE, DONE} state_t;

    state_t                state_q, state_d;
    logic [ADDR_W:0]       addr_q, addr_d;
    logic [BW-1:0]         nbytes_q, nbytes_d;
    logic [BW-1:0]         bcnt_q, bcnt_d;
    logic [16*WORDS-1:0]   data_q, data_d;
    logic                  in_ready_d, mem_we_d, busy_d, frame_done_d, err_d;
    logic [ADDR_W-1:0]     mem_addr_d;
    logic [7:0]            mem_wdata_d;
    logic [ADDR_W:0]       sum;
    logic [ADDR_W:0]       end_addr;
    logic [BW-1:0]         next_idx;

    // Byte j of a burst: word j/2, high byte for even j.
    function automatic logic [7:0] pick(input logic [16*WORDS-1:0] d, input logic [BW-1:0] j);
        logic [IW-1:0] idx;
        idx = IW'({j[BW-1:1], 4'b0000}) + (j[0] ? IW'(0) : IW'(8));
        return d[idx +: 8];
    endfunction

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        nbytes_d     = nbytes_q;
        bcnt_d       = bcnt_q;
        data_d       = data_q;
        in_ready_d   = in_ready;
        mem_we_d     = 1'b0;
        mem_addr_d   = mem_addr;
        mem_wdata_d  = mem_wdata;
        frame_done_d = frame_done;
        err_d        = err;
        sum          = addr_q + (ADDR_W+1)'({in_count, 1'b0});
        end_addr     = addr_q + (ADDR_W+1)'(nbytes_q);
        next_idx     = bcnt_q + BW'(1);

        case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d      = ACCEPT;
                    addr_d       = '0;
                    err_d        = 1'b0;
                    frame_done_d = 1'b0;
                    in_ready_d   = 1'b1;
                end
            end
            ACCEPT: begin
                if (!in_ready) begin
                    in_ready_d = 1'b1;
                end else if (in_valid) begin
                    in_ready_d = 1'b0;
                    data_d     = in_data;
                    if (in_count == 4'd0 || in_count > MAXC) begin
                        err_d = 1'b1;
                    end else begin
                        state_d     = WRITE;
                        bcnt_d      = '0;
                        nbytes_d    = BW'({in_count, 1'b0});
                        mem_we_d    = 1'b1;
                        mem_addr_d  = addr_q[ADDR_W-1:0];
                        mem_wdata_d = in_data[15:8];
                        // Clip at the frame end so mem_addr stays below DEPTH.
                        if (sum > DEPTH_W) begin
                            err_d    = 1'b1;
                            nbytes_d = BW'(DEPTH_W - addr_q);
                        end
                    end
                end
            end
            WRITE: begin
                if (next_idx < nbytes_q) begin
                    bcnt_d      = next_idx;
                    mem_we_d    = 1'b1;
                    mem_addr_d  = addr_q[ADDR_W-1:0] + ADDR_W'(next_idx);
                    mem_wdata_d = pick(data_q, next_idx);
                end else begin
                    addr_d = end_addr;
                    if (end_addr == DEPTH_W) begin
                        state_d      = DONE;
                        frame_done_d = 1'b1;
                    end else begin
                        state_d    = ACCEPT;
                        in_ready_d = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d == ACCEPT) || (state_d == WRITE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            nbytes_q   <= '0;
            bcnt_q     <= '0;
            data_q     <= '0;
            in_ready   <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            nbytes_q   <= nbytes_d;
            bcnt_q     <= bcnt_d;
            data_q     <= data_d;
            in_ready   <= in_ready_d;
            mem_we     <= mem_we_d;
            mem_addr   <= mem_addr_d;
            mem_wdata  <= mem_wdata_d;
            busy       <= busy_d;
            frame_done <= frame_done_d;
            err        <= err_d;
        end
    end

endmodule

// File: tb/tb_image_ram_writer.sv
// Directed bench for image_ram_writer, using a reduced 600-byte frame.
module tb_image_ram_writer;

    localparam int TD = 600;
    localparam int AW = 19;
    localparam int W  = 10;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [16*W-1:0] in_data = '0;
    logic [3:0]      in_count = '0;
    logic            mem_we;
    logic [AW-1:0]   mem_addr;
    logic [7:0]      mem_wdata;
    logic            busy;
    logic            frame_done;
    logic            err;

    image_ram_writer #(.DEPTH(TD), .ADDR_W(AW), .WORDS(W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_count(in_count),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .busy(busy), .frame_done(frame_done), .err(err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [AW-1:0] wa [0:31];
    logic [7:0]    wd [0:31];
    int nw;
    bit hs_ok;
    logic [16*W-1:0] fd;

    function automatic logic [16*W-1:0] full_data();
        logic [16*W-1:0] d;
        d = '0;
        for (int k = 0; k < W; k++) d[16*k +: 16] = {8'(2*k), 8'(2*k+1)};
        return d;
    endfunction

    task automatic wait_ready(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            if (in_ready) begin
                ok = 1'b1;
                break;
            end
            @(posedge clk); #1;
        end
    endtask

    // Drive one burst and record the byte writes that follow it.
    task automatic send(input logic [3:0] cnt, input logic [16*W-1:0] d);
        bit ok;
        wait_ready(ok);
        hs_ok = ok;
        nw = 0;
        if (!ok) return;
        in_valid = 1'b1; in_count = cnt; in_data = d;
        @(posedge clk); #1;
        in_valid = 1'b0;
        for (int i = 0; i < 32; i++) begin
            if (!mem_we) break;
            wa[nw] = mem_addr; wd[nw] = mem_wdata; nw++;
            @(posedge clk); #1;
        end
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_in_ready: got %b want 0", in_ready); end
        total++; if (mem_we !== 1'b0) begin bad++; $display("FAIL rst_mem_we: got %b want 0", mem_we); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
        total++; if (frame_done !== 1'b0) begin bad++; $display("FAIL rst_frame_done: got %b want 0", frame_done); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL rst_err: got %b want 0", err); end
        total++; if (mem_addr !== '0) begin bad++; $display("FAIL rst_mem_addr: got %0d want 0", mem_addr); end
        rst_n = 1'b1;
        @(posedge clk); #1;
        total++; if (in_ready !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL idle_hold: in_ready=%b busy=%b want 0 0", in_ready, busy); end
    endtask

    task automatic test_basic();
        logic [16*W-1:0] d;
        pulse_start();
        total++; if (in_ready !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL start_accept: in_ready=%b busy=%b want 1 1", in_ready, busy); end
        d = '0; d[31:0] = {16'hC3D4, 16'hA1B2};
        send(4'd2, d);
        total++; if (nw !== 4) begin bad++; $display("FAIL basic_nw: got %0d want 4", nw); end
        total++; if (wa[0] !== 19'd0 || wa[3] !== 19'd3) begin bad++; $display("FAIL basic_addr: got %0d..%0d want 0..3", wa[0], wa[3]); end
        total++; if ({wd[0], wd[1], wd[2], wd[3]} !== 32'hA1B2C3D4) begin bad++; $display("FAIL basic_data: got %h%h%h%h want a1b2c3d4", wd[0], wd[1], wd[2], wd[3]); end
        total++; if (in_ready !== 1'b1 || err !== 1'b0) begin bad++; $display("FAIL basic_after: in_ready=%b err=%b want 1 0", in_ready, err); end
    endtask

    task automatic test_illegal();
        logic [16*W-1:0] d;
        d = '0;
        send(4'd0, d);
        total++; if (hs_ok !== 1'b1 || nw !== 0) begin bad++; $display("FAIL cnt0: hs=%b nw=%0d want 1 0", hs_ok, nw); end
        total++; if (err !== 1'b1 || busy !== 1'b1) begin bad++; $display("FAIL cnt0_err: err=%b busy=%b want 1 1", err, busy); end
        send(4'd11, d);
        total++; if (hs_ok !== 1'b1 || nw !== 0) begin bad++; $display("FAIL cnt11: hs=%b nw=%0d want 1 0", hs_ok, nw); end
        d[15:0] = 16'h5566;
        send(4'd1, d);
        total++; if (nw !== 2 || wa[0] !== 19'd4 || wa[1] !== 19'd5) begin bad++; $display("FAIL cnt1_addr: nw=%0d a=%0d,%0d want 2 4,5", nw, wa[0], wa[1]); end
        total++; if (wd[0] !== 8'h55 || wd[1] !== 8'h66) begin bad++; $display("FAIL cnt1_data: got %h %h want 55 66", wd[0], wd[1]); end
        total++; if (err !== 1'b1) begin bad++; $display("FAIL err_sticky: got %b want 1", err); end
    endtask

    task automatic test_midreset();
        bit ok;
        logic [16*W-1:0] d;
        wait_ready(ok);
        total++; if (!ok) begin bad++; $display("FAIL mr_ready: in_ready=%b want 1", in_ready); end
        in_valid = 1'b1; in_count = 4'd10; in_data = fd;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) begin @(posedge clk); #1; end
        total++; if (mem_we !== 1'b1 || mem_addr !== 19'd10) begin bad++; $display("FAIL mr_byte5: we=%b addr=%0d want 1 10", mem_we, mem_addr); end
        #2 rst_n = 1'b0;
        #1;
        total++; if (mem_we !== 1'b0 || in_ready !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL mr_ctrl: we=%b rdy=%b busy=%b want 0 0 0", mem_we, in_ready, busy); end
        total++; if (err !== 1'b0 || frame_done !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin bad++; $display("FAIL mr_state: err=%b fd=%b addr=%0d wd=%h want 0 0 0 00", err, frame_done, mem_addr, mem_wdata); end
        @(posedge clk); #1;
        rst_n = 1'b1;
        pulse_start();
        d = '0; d[15:0] = 16'hBEEF;
        send(4'd1, d);
        total++; if (nw !== 2 || wa[0] !== 19'd0 || wd[0] !== 8'hBE || wd[1] !== 8'hEF) begin bad++; $display("FAIL mr_restart: nw=%0d a=%0d d=%h%h want 2 0 beef", nw, wa[0], wd[0], wd[1]); end
    endtask

    task automatic test_frame();
        logic [16*W-1:0] d;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        pulse_start();
        for (int b = 0; b < TD/20; b++) begin
            send(4'd10, fd);
            total++;
            if (nw !== 20 || wa[0] !== 19'(b*20)) begin
                bad++; $display("FAIL frame_burst%0d: nw=%0d addr=%0d want 20 %0d", b, nw, wa[0], b*20);
            end
        end
        total++; if (wa[19] !== 19'(TD-1) || wd[19] !== 8'h13) begin bad++; $display("FAIL frame_last: addr=%0d d=%h want %0d 13", wa[19], wd[19], TD-1); end
        total++; if (frame_done !== 1'b1 || in_ready !== 1'b0 || busy !== 1'b0) begin bad++; $display("FAIL frame_done: fd=%b rdy=%b busy=%b want 1 0 0", frame_done, in_ready, busy); end
        total++; if (err !== 1'b0) begin bad++; $display("FAIL frame_err: got %b want 0", err); end
        pulse_start();
        total++; if (frame_done !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL restart: fd=%b rdy=%b want 0 1", frame_done, in_ready); end
        d = '0; d[15:0] = 16'h0102;
        send(4'd1, d);
        total++; if (nw !== 2 || wa[0] !== 19'd0 || wd[0] !== 8'h01) begin bad++; $display("FAIL restart_write: nw=%0d a=%0d d=%h want 2 0 01", nw, wa[0], wd[0]); end
    endtask

    task automatic test_truncate();
        logic [16*W-1:0] d;
        for (int b = 0; b < 29; b++) send(4'd10, fd);
        send(4'd7, fd);
        total++; if (nw !== 14 || wa[13] !== 19'd595 || err !== 1'b0) begin bad++; $display("FAIL trunc_pre: nw=%0d a=%0d err=%b want 14 595 0", nw, wa[13], err); end
        d = '0; d[47:0] = {16'hEEFF, 16'hCCDD, 16'hAABB};
        send(4'd3, d);
        total++; if (nw !== 4) begin bad++; $display("FAIL trunc_nw: got %0d want 4", nw); end
        total++; if (wa[0] !== 19'd596 || wa[3] !== 19'd599) begin bad++; $display("FAIL trunc_addr: %0d..%0d want 596..599", wa[0], wa[3]); end
        total++; if (wd[0] !== 8'hAA || wd[3] !== 8'hDD) begin bad++; $display("FAIL trunc_data: %h %h want aa dd", wd[0], wd[3]); end
        total++; if (err !== 1'b1 || frame_done !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL trunc_flags: err=%b fd=%b rdy=%b want 1 1 0", err, frame_done, in_ready); end
    endtask

    task automatic test_back_to_back();
        bit ok;
        pulse_start();
        total++; if (err !== 1'b0) begin bad++; $display("FAIL start_clr_err: got %b want 0", err); end
        wait_ready(ok);
        in_valid = 1'b1; in_count = 4'd5;
        in_data = '0; in_data[79:0] = {16'h8899, 16'h6677, 16'h4455, 16'h2233, 16'h0011};
        @(posedge clk); #1;
        in_count = 4'd2;
        in_data = '0; in_data[31:0] = {16'h5678, 16'h1234};
        nw = 0;
        for (int i = 0; i < 32; i++) begin
            if (!mem_we) break;
            wa[nw] = mem_addr; wd[nw] = mem_wdata; nw++;
            start = (nw == 3);
            @(posedge clk); #1;
        end
        start = 1'b0;
        total++; if (nw !== 10 || wa[0] !== 19'd0 || wa[9] !== 19'd9) begin bad++; $display("FAIL hold_writes: nw=%0d a=%0d..%0d want 10 0..9", nw, wa[0], wa[9]); end
        total++; if (wd[1] !== 8'h11 || wd[9] !== 8'h99) begin bad++; $display("FAIL hold_data: %h %h want 11 99", wd[1], wd[9]); end
        total++; if (in_ready !== 1'b1 || mem_we !== 1'b0) begin bad++; $display("FAIL hold_gap: rdy=%b we=%b want 1 0", in_ready, mem_we); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        total++; if (mem_we !== 1'b1 || mem_addr !== 19'd10 || mem_wdata !== 8'h12) begin bad++; $display("FAIL hold_accept: we=%b a=%0d d=%h want 1 10 12", mem_we, mem_addr, mem_wdata); end
        total++; if (busy !== 1'b1 || in_ready !== 1'b0) begin bad++; $display("FAIL hold_busy: busy=%b rdy=%b want 1 0", busy, in_ready); end
    endtask

    initial begin
        fd = full_data();
        test_reset();
        test_basic();
        test_illegal();
        test_midreset();
        test_frame();
        test_truncate();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
